signal_conflict_monitor: RTL and testbench

Safety stage directly downstream of Traffic_Light_Controller. It consumes the four 3-bit approach lights (M1, M2, MT, S) and checks each cycle for illegal encodings, conflicting greens, illegal colour sequences and short yellows. When clean, it passes the lights to the lamp drivers with one cycle of latency. On any fault it latches a fault code and forces all approaches to flashing red until an operator clear.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/lamp_seq_checker.sv | 55 +++++
 rtl/signal_conflict_monitor.sv | 145 ++++++++++++++
 tb/tb_signal_conflict_monitor.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light encodings, fault codes and approach indices for the
// signal conflict monitor and its per-approach checkers.
package traffic_pkg;

    typedef logic [2:0] light_t;

    localparam light_t RED = 3'b100;
    localparam light_t YEL = 3'b010;
    localparam light_t GRN = 3'b001;
    localparam light_t OFF = 3'b000;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ILLEGAL  = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;
    localparam logic [2:0] FC_SHORT_YL = 3'd4;

    localparam int unsigned AP_M1 = 0;
    localparam int unsigned AP_M2 = 1;
    localparam int unsigned AP_MT = 2;
    localparam int unsigned AP_S  = 3;
    localparam int unsigned NUM_AP = 4;

    function automatic logic is_legal(input light_t l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

endpackage

// File: rtl/lamp_seq_checker.sv
// Per-approach checker: encoding legality, colour transition legality and
// minimum yellow dwell, gated by a history-valid flag after reset/clear.
module lamp_seq_checker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hist_clear,
    input  logic [2:0] light,
    output logic       illegal_enc,
    output logic       seq_err,
    output logic       short_yel
);

    localparam int unsigned CW = (MIN_YELLOW < 1) ? 1 : $clog2(MIN_YELLOW + 1);

    light_t        prev;
    logic [CW-1:0] ycnt;
    logic          hist_valid;
    logic          legal_step;

    always_comb begin
        legal_step = (light == prev)
                  || ((prev == RED) && (light == GRN))
                  || ((prev == GRN) && (light == YEL))
                  || ((prev == YEL) && (light == RED));
        illegal_enc = !is_legal(light);
        seq_err     = hist_valid && !illegal_enc && !legal_step;
        short_yel   = hist_valid && (prev == YEL) && (light == RED)
                   && (ycnt < CW'(MIN_YELLOW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev       <= RED;
            ycnt       <= '0;
            hist_valid <= 1'b0;
        end else begin
            prev       <= light;
            hist_valid <= !hist_clear;
            // ycnt counts consecutive yellow samples, saturating at MIN_YELLOW
            if (light == YEL) begin
                if (prev != YEL)
                    ycnt <= CW'(1);
                else if (ycnt < CW'(MIN_YELLOW))
                    ycnt <= ycnt + CW'(1);
            end else begin
                ycnt <= '0;
            end
        end
    end

endmodule

// File: rtl/signal_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers:
// passes lights with one cycle latency, or latches a fault and flashes red.
module signal_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned FLASH_HALF = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [3:0] fault_src
);

    localparam logic [0:0] ST_PASS  = 1'b0;
    localparam logic [0:0] ST_FLASH = 1'b1;

    localparam int unsigned FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    light_t     in_l   [NUM_AP];
    light_t     lamp_r [NUM_AP];
    logic [3:0] illegal_v;
    logic [3:0] seq_v;
    logic [3:0] short_v;
    logic [3:0] green_v;
    logic       conflict;
    logic       all_red;
    logic       exit_req;
    logic       hist_clear;
    logic [2:0] det_code;
    logic [3:0] det_src;

    logic [0:0]    state;
    logic          phase;
    logic [FW-1:0] fcnt;
    logic [2:0]    code_r;
    logic [3:0]    src_r;

    assign in_l[AP_M1] = light_M1;
    assign in_l[AP_M2] = light_M2;
    assign in_l[AP_MT] = light_MT;
    assign in_l[AP_S]  = light_S;

    for (genvar i = 0; i < NUM_AP; i++) begin : g_chk
        lamp_seq_checker #(
            .MIN_YELLOW(MIN_YELLOW)
        ) u_chk (
            .clk        (clk),
            .rst        (rst),
            .hist_clear (hist_clear),
            .light      (in_l[i]),
            .illegal_enc(illegal_v[i]),
            .seq_err    (seq_v[i]),
            .short_yel  (short_v[i])
        );
        assign green_v[i] = (in_l[i] == GRN);
    end

    always_comb begin
        conflict = (green_v[AP_S] && (green_v[AP_M1] || green_v[AP_M2] || green_v[AP_MT]))
                || (green_v[AP_M2] && green_v[AP_MT]);
        all_red  = (light_M1 == RED) && (light_M2 == RED)
                && (light_MT == RED) && (light_S == RED);
        exit_req   = fault_clr && all_red;
        hist_clear = (state == ST_FLASH) && exit_req;

        det_code = FC_NONE;
        det_src  = '0;
        if (|illegal_v) begin
            det_code = FC_ILLEGAL;
            det_src  = illegal_v;
        end else if (conflict) begin
            det_code = FC_CONFLICT;
            det_src  = green_v;
        end else if (|seq_v) begin
            det_code = FC_SEQUENCE;
            det_src  = seq_v;
        end else if (|short_v) begin
            det_code = FC_SHORT_YL;
            det_src  = short_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_PASS;
            phase  <= 1'b1;
            fcnt   <= '0;
            code_r <= FC_NONE;
            src_r  <= '0;
            for (int unsigned i = 0; i < NUM_AP; i++) lamp_r[i] <= RED;
        end else begin
            case (state)
                ST_PASS: begin
                    if (det_code != FC_NONE) begin
                        state  <= ST_FLASH;
                        phase  <= 1'b1;
                        fcnt   <= '0;
                        code_r <= det_code;
                        src_r  <= det_src;
                        for (int unsigned i = 0; i < NUM_AP; i++) lamp_r[i] <= RED;
                    end else begin
                        for (int unsigned i = 0; i < NUM_AP; i++) lamp_r[i] <= in_l[i];
                    end
                end
                default: begin
                    if (exit_req) begin
                        state  <= ST_PASS;
                        phase  <= 1'b1;
                        fcnt   <= '0;
                        code_r <= FC_NONE;
                        src_r  <= '0;
                        for (int unsigned i = 0; i < NUM_AP; i++) lamp_r[i] <= RED;
                    end else if (fcnt == FW'(FLASH_HALF - 1)) begin
                        // phase holds the half-period just finished; next lamps take its complement
                        fcnt  <= '0;
                        phase <= !phase;
                        for (int unsigned i = 0; i < NUM_AP; i++) lamp_r[i] <= phase ? OFF : RED;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
            endcase
        end
    end

    assign lamp_M1    = lamp_r[AP_M1];
    assign lamp_M2    = lamp_r[AP_M2];
    assign lamp_MT    = lamp_r[AP_MT];
    assign lamp_S     = lamp_r[AP_S];
    assign fault      = (state == ST_FLASH);
    assign fault_code = code_r;
    assign fault_src  = src_r;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor with hand-computed expectations.
module tb_signal_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [11:0] ALL_RED = 12'h924;
    localparam logic [11:0] ALL_OFF = 12'h000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       fault_clr;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic       fault;
    logic [2:0] fault_code;
    logic [3:0] fault_src;

    int total = 0;
    int bad   = 0;

    signal_conflict_monitor #(
        .MIN_YELLOW(3),
        .FLASH_HALF(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .light_M1  (light_M1),
        .light_M2  (light_M2),
        .light_MT  (light_MT),
        .light_S   (light_S),
        .fault_clr (fault_clr),
        .lamp_M1   (lamp_M1),
        .lamp_M2   (lamp_M2),
        .lamp_MT   (lamp_MT),
        .lamp_S    (lamp_S),
        .fault     (fault),
        .fault_code(fault_code),
        .fault_src (fault_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] m1, input logic [2:0] m2, input logic [2:0] mt,
                        input logic [2:0] s, input logic clr);
        light_M1  = m1;
        light_M2  = m2;
        light_MT  = mt;
        light_S   = s;
        fault_clr = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lamps();
        return {20'd0, lamp_M1, lamp_M2, lamp_MT, lamp_S};
    endfunction

    initial begin
        rst = 1'b1;
        step(R, R, R, R, 0);
        step(R, R, R, R, 0);
        chk("rst_lamps", lamps(), ALL_RED);
        chk("rst_fault", fault, 1'b0);
        chk("rst_code", fault_code, 3'd0);
        chk("rst_src", fault_src, 4'd0);
        rst = 1'b0;

        // legal main-road cycle then side road green
        step(R, R, R, R, 0);
        step(G, G, R, R, 0);
        chk("pass_green_lamps", lamps(), {20'd0, G, G, R, R});
        chk("pass_green_fault", fault, 1'b0);
        step(Y, Y, R, R, 0);
        chk("pass_yel_lamp", lamp_M1, Y);
        step(Y, Y, R, R, 0);
        step(Y, Y, R, R, 0);
        step(R, R, R, R, 0);
        chk("full_yel_fault", fault, 1'b0);
        chk("full_yel_lamps", lamps(), ALL_RED);
        step(R, R, R, G, 0);
        chk("side_green_lamp", lamp_S, G);
        chk("side_green_fault", fault, 1'b0);
        step(R, R, R, Y, 0);
        step(R, R, R, Y, 0);
        step(R, R, R, Y, 0);
        step(R, R, R, R, 0);
        chk("side_cycle_fault", fault, 1'b0);

        // M2 + MT conflict
        step(R, G, G, R, 0);
        chk("conf_fault", fault, 1'b1);
        chk("conf_code", fault_code, 3'd2);
        chk("conf_src", fault_src, 4'b0110);
        chk("conf_lamps_on", lamps(), ALL_RED);
        step(R, G, G, R, 0);
        chk("flash_off", lamps(), ALL_OFF);
        step(R, G, G, R, 0);
        chk("flash_on", lamps(), ALL_RED);
        step(G, R, R, R, 1);
        chk("clr_nonred_fault", fault, 1'b1);
        chk("clr_nonred_code", fault_code, 3'd2);
        chk("clr_nonred_lamps", lamps(), ALL_OFF);
        step(R, R, R, R, 1);
        chk("exit_fault", fault, 1'b0);
        chk("exit_code", fault_code, 3'd0);
        chk("exit_src", fault_src, 4'd0);
        chk("exit_lamps", lamps(), ALL_RED);

        // R->Y right after exit is suppressed; then only 2 yellows before red
        step(Y, R, R, R, 0);
        chk("post_exit_fault", fault, 1'b0);
        chk("post_exit_lamp", lamp_M1, Y);
        step(Y, R, R, R, 0);
        chk("yel2_fault", fault, 1'b0);
        step(R, R, R, R, 0);
        chk("short_fault", fault, 1'b1);
        chk("short_code", fault_code, 3'd4);
        chk("short_src", fault_src, 4'b0001);
        step(R, R, R, R, 1);
        chk("exit2_fault", fault, 1'b0);

        // G->R is an illegal sequence
        step(G, R, R, R, 0);
        chk("g_fault", fault, 1'b0);
        chk("g_lamp", lamp_M1, G);
        step(R, R, R, R, 0);
        chk("seq_code", fault_code, 3'd3);
        chk("seq_src", fault_src, 4'b0001);
        step(R, R, R, R, 1);
        chk("exit3_fault", fault, 1'b0);

        // illegal encoding outranks simultaneous conflict
        step(G, G, G, 3'b011, 0);
        chk("illeg_fault", fault, 1'b1);
        chk("illeg_code", fault_code, 3'd1);
        chk("illeg_src", fault_src, 4'b1000);

        // reset mid-flash, then first sample yellow is not a sequence error
        step(R, R, R, R, 0);
        rst = 1'b1;
        step(R, R, R, R, 0);
        chk("rst_flash_fault", fault, 1'b0);
        chk("rst_flash_lamps", lamps(), ALL_RED);
        chk("rst_flash_code", fault_code, 3'd0);
        rst = 1'b0;
        step(Y, R, R, R, 0);
        chk("rst_yel_fault", fault, 1'b0);
        chk("rst_yel_lamp", lamp_M1, Y);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
